// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags: rename pops at head, commit pushes at tail,
// flush rewinds head to the committed pointer. Define FREE_LIST_CHECK_EN for a sticky err_o.
module phys_reg_free_list #(
  parameter int PHY_REGS  = 64,
  parameter int ARCH_REGS = 32,
  parameter int PHY_WIDTH = $clog2(PHY_REGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req_i,
  output logic                 alloc_valid_o,
  output logic [PHY_WIDTH-1:0] alloc_preg_o,
  input  logic                 release_valid_i,
  input  logic [PHY_WIDTH-1:0] release_preg_i,
  input  logic                 commit_alloc_i,
  input  logic                 flush_i,
  output logic [PHY_WIDTH:0]   free_count_o,
  output logic                 err_o
);

  typedef logic [PHY_WIDTH:0]   ptr_t;
  typedef logic [PHY_WIDTH-1:0] tag_t;

  localparam ptr_t FULL_COUNT = ptr_t'(PHY_REGS);
  localparam ptr_t INIT_TAIL  = ptr_t'(PHY_REGS - ARCH_REGS);

  tag_t mem_q [PHY_REGS];
  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  ptr_t commit_head_q, commit_head_d;

  ptr_t count;
  logic full;
  logic alloc_fire;
  logic release_fire;
  logic commit_fire;

  // The wrap bit makes tail - head range over 0..PHY_REGS, so full and empty differ.
  assign count         = tail_q - head_q;
  assign full          = (count == FULL_COUNT);
  assign alloc_valid_o = (count != '0);
  assign alloc_preg_o  = mem_q[head_q[PHY_WIDTH-1:0]];
  assign free_count_o  = count;

  assign alloc_fire   = alloc_req_i && alloc_valid_o && !flush_i;
  assign release_fire = release_valid_i && (release_preg_i != '0) && !full;
  assign commit_fire  = commit_alloc_i && (commit_head_q != head_q);

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    commit_head_d = commit_head_q;
    head_d        = head_q;
    tail_d        = tail_q;

    if (commit_fire) begin
      commit_head_d = commit_head_q + ptr_t'(1);
    end

    // A flush discards every speculative pop, including any request in the same cycle.
    if (flush_i) begin
      head_d = commit_head_d;
    end else if (alloc_fire) begin
      head_d = head_q + ptr_t'(1);
    end

    if (release_fire) begin
      tail_d = tail_q + ptr_t'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= INIT_TAIL;
    end else begin
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
    end
  end

  // NOTE: the storage is reset because its initial contents are the architecturally
  // meaningful pool of free tags, not don't-care data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHY_REGS; i++) begin
        if (i < PHY_REGS - ARCH_REGS) begin
          mem_q[i] <= tag_t'(ARCH_REGS + i);
        end else begin
          mem_q[i] <= '0;
        end
      end
    end else if (release_fire) begin
      mem_q[tail_q[PHY_WIDTH-1:0]] <= release_preg_i;
    end
  end

`ifdef FREE_LIST_CHECK_EN
  logic err_q, err_d;
  logic drop_event;

  assign drop_event = (release_valid_i && ((release_preg_i == '0) || full))
                   || (commit_alloc_i && !commit_fire)
                   || (alloc_req_i && !alloc_valid_o);

  always_comb begin
    err_d = err_q | drop_event;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed and model-checked bench for phys_reg_free_list (default and FREE_LIST_CHECK_EN builds).
module tb_phys_reg_free_list;

  localparam int PHY_REGS  = 64;
  localparam int ARCH_REGS = 32;
  localparam int PHY_WIDTH = 6;

`ifdef FREE_LIST_CHECK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic                 clk;
  logic                 rst;
  logic                 alloc_req_i;
  logic                 alloc_valid_o;
  logic [PHY_WIDTH-1:0] alloc_preg_o;
  logic                 release_valid_i;
  logic [PHY_WIDTH-1:0] release_preg_i;
  logic                 commit_alloc_i;
  logic                 flush_i;
  logic [PHY_WIDTH:0]   free_count_o;
  logic                 err_o;

  int n_cmp = 0;
  int n_err = 0;

  phys_reg_free_list #(
    .PHY_REGS (PHY_REGS),
    .ARCH_REGS(ARCH_REGS),
    .PHY_WIDTH(PHY_WIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_req_i    (alloc_req_i),
    .alloc_valid_o  (alloc_valid_o),
    .alloc_preg_o   (alloc_preg_o),
    .release_valid_i(release_valid_i),
    .release_preg_i (release_preg_i),
    .commit_alloc_i (commit_alloc_i),
    .flush_i        (flush_i),
    .free_count_o   (free_count_o),
    .err_o          (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle();
    alloc_req_i     = 1'b0;
    release_valid_i = 1'b0;
    release_preg_i  = '0;
    commit_alloc_i  = 1'b0;
    flush_i         = 1'b0;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    #2;
    check("rst_valid", int'(alloc_valid_o), 1);
    check("rst_preg",  int'(alloc_preg_o), ARCH_REGS);
    check("rst_count", int'(free_count_o), PHY_REGS - ARCH_REGS);
    check("rst_err",   int'(err_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_req_i = 1'b1;
      cycle();
    end
    alloc_req_i = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fq[$];
    int live[$];
    idle();
    rst = 1'b0;

    // Drain the 32 initial free tags, then request while empty.
    do_reset();
    for (int i = 0; i < PHY_REGS - ARCH_REGS; i++) begin
      alloc_req_i = 1'b1;
      check("drain_valid", int'(alloc_valid_o), 1);
      check("drain_tag", int'(alloc_preg_o), ARCH_REGS + i);
      cycle();
    end
    alloc_req_i = 1'b0;
    check("empty_valid", int'(alloc_valid_o), 0);
    check("empty_count", int'(free_count_o), 0);
    alloc_req_i = 1'b1;
    cycle();
    alloc_req_i = 1'b0;
    check("empty_req_count", int'(free_count_o), 0);
    check("empty_req_valid", int'(alloc_valid_o), 0);
    check("empty_req_err", int'(err_o), ERR_EXP);

    // Release into an empty list with a simultaneous request.
    release_valid_i = 1'b1;
    release_preg_i  = 6'd40;
    alloc_req_i     = 1'b1;
    check("rel_empty_nogrant", int'(alloc_valid_o), 0);
    cycle();
    idle();
    check("rel_empty_valid", int'(alloc_valid_o), 1);
    check("rel_empty_tag", int'(alloc_preg_o), 40);
    check("rel_empty_count", int'(free_count_o), 1);

    // Five allocs, two commits, flush: head rewinds to 2.
    do_reset();
    alloc_n(5);
    check("a5_tag", int'(alloc_preg_o), 37);
    commit_alloc_i = 1'b1;
    cycle();
    cycle();
    commit_alloc_i = 1'b0;
    flush_i = 1'b1;
    alloc_req_i = 1'b1;
    cycle();
    idle();
    check("flush_tag", int'(alloc_preg_o), 34);
    check("flush_count", int'(free_count_o), 30);
    check("flush_err", int'(err_o), 0);

    // Three allocs, one commit, then flush together with a commit.
    do_reset();
    alloc_n(3);
    commit_alloc_i = 1'b1;
    cycle();
    flush_i = 1'b1;
    cycle();
    idle();
    check("flush_commit_tag", int'(alloc_preg_o), 34);
    check("flush_commit_count", int'(free_count_o), 30);

    // Release of tag 0 is dropped.
    do_reset();
    release_valid_i = 1'b1;
    release_preg_i  = '0;
    cycle();
    idle();
    check("rel0_count", int'(free_count_o), 32);
    check("rel0_err", int'(err_o), ERR_EXP);

    // Fill to 64, drop a release while full, then drain across the wrap.
    do_reset();
    for (int i = 1; i <= 32; i++) begin
      release_valid_i = 1'b1;
      release_preg_i  = PHY_WIDTH'(i);
      cycle();
    end
    idle();
    check("full_count", int'(free_count_o), 64);
    check("full_err_clean", int'(err_o), 0);
    release_valid_i = 1'b1;
    release_preg_i  = 6'd5;
    cycle();
    idle();
    check("full_drop_count", int'(free_count_o), 64);
    check("full_drop_err", int'(err_o), ERR_EXP);
    for (int i = 0; i < 64; i++) begin
      alloc_req_i = 1'b1;
      check("wrap_tag", int'(alloc_preg_o), (i < 32) ? (32 + i) : (i - 31));
      cycle();
    end
    alloc_req_i = 1'b0;
    check("wrap_empty_valid", int'(alloc_valid_o), 0);
    check("wrap_empty_count", int'(free_count_o), 0);

    // Commit with nothing outstanding is dropped.
    do_reset();
    commit_alloc_i = 1'b1;
    cycle();
    idle();
    check("commit_drop_count", int'(free_count_o), 32);
    check("commit_drop_err", int'(err_o), ERR_EXP);
    alloc_n(1);
    flush_i = 1'b1;
    cycle();
    idle();
    check("commit_drop_flush_tag", int'(alloc_preg_o), 32);

    // Random alloc/release against a FIFO model of the tag pool.
    do_reset();
    fq.delete();
    live.delete();
    for (int t = 32; t < 64; t++) fq.push_back(t);
    for (int t = 1; t < 32; t++) live.push_back(t);
    for (int it = 0; it < 200; it++) begin
      bit do_alloc;
      bit do_rel;
      int rtag;
      do_alloc = ($urandom_range(0, 1) == 1);
      do_rel   = ($urandom_range(0, 2) != 0) && (live.size() > 0);
      rtag = 0;
      if (do_rel) begin
        int idx;
        idx = $urandom_range(0, live.size() - 1);
        rtag = live[idx];
        live.delete(idx);
      end
      alloc_req_i     = do_alloc;
      release_valid_i = do_rel;
      release_preg_i  = PHY_WIDTH'(rtag);
      check("rnd_count", int'(free_count_o), fq.size());
      check("rnd_valid", int'(alloc_valid_o), (fq.size() != 0) ? 1 : 0);
      if (fq.size() != 0) begin
        check("rnd_tag", int'(alloc_preg_o), fq[0]);
        if (do_alloc) begin
          int got;
          int found;
          got = int'(alloc_preg_o);
          found = 0;
          foreach (live[j]) if (live[j] == got) found = 1;
          check("rnd_unique", found, 0);
          void'(fq.pop_front());
          live.push_back(got);
        end
      end
      if (do_rel) fq.push_back(rtag);
      cycle();
    end
    idle();
    check("rnd_final_count", int'(free_count_o), fq.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Circular free list of physical register tags for the out-of-order core. The rename stage pops free tags for new destinations, and ROB commit pushes back the previous mappings of retired instructions. A committed read pointer lets a pipeline flush return every speculatively allocated tag in one cycle. The block sits between rename (consumer end) and commit (producer end).

## Interface
- PHY_REGS, 64, number of physical registers; power of two; also the storage depth
- ARCH_REGS, 32, architectural registers; tags 0..ARCH_REGS-1 are mapped at reset and are not free
- PHY_WIDTH, $clog2(PHY_REGS), tag width
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- alloc_req_i  input  1  rename pops one tag this cycle
- alloc_valid_o  output  1  a free tag is available
- alloc_preg_o  output  PHY_WIDTH  tag at the head of the list
- release_valid_i  input  1  commit returns a tag
- release_preg_i  input  PHY_WIDTH  tag being returned
- commit_alloc_i  input  1  retiring instruction owned an allocated destination; advances the committed pointer
- flush_i  input  1  misprediction/exception recovery
- free_count_o  output  PHY_WIDTH+1  number of free tags
- err_o  output  1  sticky protocol error (see Configuration)

## Operation
- Storage: PHY_REGS entries × PHY_WIDTH bits.
- Pointers: head, tail and commit_head, each PHY_WIDTH+1 bits. The MSB is the wrap bit.
- Derived values:
  - count = tail − head (mod 2^(PHY_WIDTH+1))
  - alloc_valid_o = (count != 0)
  - alloc_preg_o = mem[head[PHY_WIDTH-1:0]]
  - free_count_o = count
- Reset: mem[i] = ARCH_REGS + i for i < PHY_REGS−ARCH_REGS; head = commit_head = 0; tail = PHY_REGS−ARCH_REGS.
- Allocate: when alloc_req_i && alloc_valid_o && !flush_i, head increments. If alloc_req_i is asserted while empty, nothing happens.
- Release: when release_valid_i, release_preg_i != 0 and count != PHY_REGS, write mem[tail] and increment tail.
  - A release of tag 0 (x0's permanent mapping) is dropped.
  - A release while full is dropped.
  - A release is accepted in a flush cycle.
- Commit: when commit_alloc_i and commit_head != head, commit_head increments. If commit_head == head, the request is dropped.
- Flush: head ← commit_head + (accepted commit_alloc_i ? 1 : 0). Any alloc_req_i in that cycle is ignored.
- Simultaneous allocate and release: both happen, and count is unchanged.
- At count==0 the tag being released is not visible until the next cycle.
- Wrap-around: pointers wrap naturally, and the wrap bit distinguishes full from empty.

## Timing
- Allocation is zero-latency: alloc_preg_o and alloc_valid_o are combinational from registered state and valid in the request cycle. The pop takes effect at the clock edge.
- A released tag becomes allocatable 1 cycle after release (or later, by FIFO order).
- Flush takes effect at the edge. The cycle after flush, alloc_preg_o is the oldest uncommitted allocated tag.
- Reset values of outputs:
  - alloc_valid_o = 1
  - alloc_preg_o = ARCH_REGS (32)
  - free_count_o = PHY_REGS−ARCH_REGS (32)
  - err_o = 0
- Asserting rst mid-operation discards all state immediately (asynchronously).

## Configuration
- FREE_LIST_CHECK_EN defined:
  - err_o is set on any dropped event: release of tag 0, release while full, commit_alloc_i with commit_head == head, or alloc_req_i while empty.
  - err_o holds at 1 until rst and is registered (visible the cycle after the event).
- Not defined: err_o is constant 0. Dropping behaviour is identical in both builds.

## Test plan
- Reset, then 32 consecutive allocs with no releases:
  - Tags returned are 32,33,…,63.
  - On the 33rd cycle alloc_valid_o=0 and free_count_o=0.
  - alloc_req_i in that cycle leaves state unchanged; err_o=1 with FREE_LIST_CHECK_EN.
- Empty list; release tag 40 and assert alloc_req_i in the same cycle:
  - No allocation is granted in that cycle.
  - Next cycle alloc_valid_o=1, alloc_preg_o=40, free_count_o=1.
- After reset, alloc 5 tags (32–36), commit_alloc_i twice, then flush_i:
  - Next cycle alloc_preg_o=34 and free_count_o=30.
- Flush with commit_alloc_i asserted in the same cycle, after 3 allocs and 1 prior commit:
  - head = 2, so alloc_preg_o=34.
- Run wrap-around: 200 cycles of random alloc/release with a model of the tag pool:
  - Every allocated tag is unique among live tags.
  - free_count_o always matches the model.
  - No tag is ever lost across pointer wrap.
- Release tag 0, and release while count=64:
  - Both are dropped and free_count_o is unchanged.
  - err_o=1 only in a FREE_LIST_CHECK_EN build.
